imem_boot_loader: RTL and testbench

Hardware instruction-memory loader for the pipelined RISC-V CPU: the write-side counterpart of the bench trace path, filling Instruction_Memory from a byte stream instead of the simulator doing it. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit words and writes them to consecutive word addresses from 0. It then raises the CPU start signal. It sits between the external boot link and the CPU's instruction memory write port and `start_i`.

---
 rtl/imem_boot_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: fills the CPU instruction memory from a length-prefixed,
// little-endian byte stream, then raises the CPU start signal.
// Stream: N[7:0], N[15:8], then N words of 4 bytes each, LSB first.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all preceding bytes, header included.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [15:0]       words_o
);

    localparam logic [2:0] StHdr0 = 3'd0;
    localparam logic [2:0] StHdr1 = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StCsum = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    // Widened so N and the word index compare against DEPTH without truncation.
    localparam logic [16:0] DepthW = 17'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       nwords_q, nwords_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [15:0]       widx_q, widx_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              start_q, start_d;
    logic              err_q, err_d;
    logic [15:0]       words_q, words_d;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign accept = rx_valid_i && rx_ready_o;

    // Next-state logic: everything advances only on an accepted byte, except
    // the delayed start after the final data write.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        nwords_d = nwords_q;
        bidx_d   = bidx_q;
        widx_d   = widx_q;
        asm_d    = asm_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        start_d  = start_q;
        err_d    = err_q;
        words_d  = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ rx_data_i;
`endif
            case (state_q)
                StHdr0: begin
                    len_lo_d = rx_data_i;
                    state_d  = StHdr1;
                end
                StHdr1: begin
                    nwords_d = {rx_data_i, len_lo_q};
                    if ({1'b0, nwords_d} > DepthW) begin
                        err_d = 1'b1;
                    end
                    if (nwords_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
                        start_d = 1'b1;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: asm_d[7:0]   = rx_data_i;
                        2'd1: asm_d[15:8]  = rx_data_i;
                        2'd2: asm_d[23:16] = rx_data_i;
                        default: begin
                            // Words past DEPTH are consumed but dropped.
                            if ({1'b0, widx_q} < DepthW) begin
                                we_d    = 1'b1;
                                addr_d  = widx_q[ADDR_W-1:0];
                                data_d  = {rx_data_i, asm_q};
                                words_d = words_q + 16'd1;
                            end
                            widx_d = widx_q + 16'd1;
                            if (widx_d == nwords_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = StCsum;
`else
                                state_d = StDone;
`endif
                            end
                        end
                    endcase
                end
                StCsum: begin
                    state_d = StDone;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (rx_data_i != csum_q) begin
                        err_d = 1'b1;
                    end else if (!err_q) begin
                        start_d = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
        // After the last data word, start follows the write strobe by a cycle.
        if (state_q == StDone && !err_q) begin
            start_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StHdr0;
            len_lo_q <= 8'd0;
            nwords_q <= 16'd0;
            bidx_q   <= 2'd0;
            widx_q   <= 16'd0;
            asm_q    <= 24'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= 32'd0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            words_q  <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            nwords_q <= nwords_d;
            bidx_q   <= bidx_d;
            widx_q   <= widx_d;
            asm_q    <= asm_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            start_q  <= start_d;
            err_q    <= err_d;
            words_q  <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign rx_ready_o  = (state_q != StDone);
    assign busy_o      = (state_q == StData) || (state_q == StCsum);
    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign cpu_start_o = start_q;
    assign err_o       = err_q;
    assign words_o     = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a default-depth instance and a
// DEPTH=4 instance share one input stream.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        rdy, we, start, busy, err;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [15:0] words;

    logic        rdy4, we4, start4, busy4, err4;
    logic [7:0]  addr4;
    logic [31:0] wdata4;
    logic [15:0] words4;

    int checks = 0;
    int failures = 0;

    imem_boot_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rdy), .imem_we_o(we), .imem_addr_o(addr), .imem_data_o(wdata),
        .cpu_start_o(start), .busy_o(busy), .err_o(err), .words_o(words)
    );

    imem_boot_loader #(.ADDR_W(8), .DEPTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rdy4), .imem_we_o(we4), .imem_addr_o(addr4), .imem_data_o(wdata4),
        .cpu_start_o(start4), .busy_o(busy4), .err_o(err4), .words_o(words4)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every strobe and flags strobes lasting two cycles.
    logic [7:0]  mon_addr[$];
    logic [31:0] mon_data[$];
    int          dbl_we = 0;
    logic        we_prev = 1'b0;
    int          we4_cnt = 0;
    logic [7:0]  last_addr4 = 8'd0;
    always @(negedge clk) begin
        if (we) begin
            mon_addr.push_back(addr);
            mon_data.push_back(wdata);
            if (we_prev) dbl_we <= dbl_we + 1;
        end
        we_prev <= we;
        if (we4) begin
            we4_cnt    <= we4_cnt + 1;
            last_addr4 <= addr4;
        end
    end

    typedef struct packed {
        logic        valid;
        logic [7:0]  data;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        start;
        logic        ready;
        logic        busy;
        logic [15:0] words;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte, wait (bounded) for acceptance, then idle for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rdy && n < 20) begin
            tick();
            n++;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_byte_refused got=ready0 exp=ready1 byte=%h", b);
            rx_valid = 1'b0;
            return;
        end
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [7:0] img [0:9];
    int base;

    initial begin
        img[0] = 8'h02; img[1] = 8'h00;
        img[2] = 8'h13; img[3] = 8'h00; img[4] = 8'h50; img[5] = 8'h00;
        img[6] = 8'hB3; img[7] = 8'h00; img[8] = 8'h00; img[9] = 8'h00;

        //           valid data    we  addr   wdata          st  rdy busy words
        vecs[0]  = '{1'b1, 8'h02, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 8'h00, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 8'h13, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 1'b1, 16'd0};
        vecs[3]  = '{1'b1, 8'h00, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 1'b1, 16'd0};
        vecs[4]  = '{1'b1, 8'h50, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 1'b1, 16'd0};
        vecs[5]  = '{1'b1, 8'h00, 1'b1, 8'd0, 32'h00500013, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[6]  = '{1'b1, 8'hB3, 1'b0, 8'd0, 32'h00500013, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[7]  = '{1'b1, 8'h00, 1'b0, 8'd0, 32'h00500013, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[8]  = '{1'b1, 8'h00, 1'b0, 8'd0, 32'h00500013, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[9]  = '{1'b1, 8'h00, 1'b1, 8'd1, 32'h000000B3, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[10] = '{1'b1, 8'hFF, 1'b0, 8'd1, 32'h000000B3, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[11] = '{1'b1, 8'hFF, 1'b0, 8'd1, 32'h000000B3, 1'b1, 1'b0, 1'b0, 16'd2};

        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) tick();
        check("reset_outputs", {rdy, we, addr, wdata, start, busy, err, words},
              {1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0});
        rst = 1'b0;
        repeat (3) tick();
        check("idle_outputs", {rdy, we, addr, wdata, start, busy, err, words},
              {1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0});

`ifndef IMEM_LOADER_CHECKSUM_EN
        // Full-rate stream, one row per clock.
        base = mon_addr.size();
        for (int i = 0; i < 12; i++) begin
            rx_valid = vecs[i].valid;
            rx_data  = vecs[i].data;
            tick();
            check($sformatf("fullrate_row%0d", i),
                  {we, addr, wdata, start, rdy, busy, err, words},
                  {vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].start,
                   vecs[i].ready, vecs[i].busy, 1'b0, vecs[i].words});
        end
        rx_valid = 1'b0;
        check("fullrate_write_count", 64'(mon_addr.size() - base), 64'd2);

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {rdy, start, addr, wdata, words},
              {1'b1, 1'b0, 8'd0, 32'd0, 16'd0});
        tick();
        rst = 1'b0;
        tick();

        // Same stream with 3 idle cycles between bytes.
        base = mon_addr.size();
        send_byte(img[0], 3);
        send_byte(img[1], 3);
        check("gap_busy_after_header", {busy, words}, {1'b1, 16'd0});
        for (int i = 2; i < 10; i++) send_byte(img[i], (i == 9) ? 0 : 3);
        check("gap_last_strobe", {we, addr, wdata, words, start},
              {1'b1, 8'd1, 32'h000000B3, 16'd2, 1'b0});
        tick();
        check("gap_start", {we, start, rdy}, {1'b0, 1'b1, 1'b0});
        check("gap_write_count", 64'(mon_addr.size() - base), 64'd2);
        if (mon_addr.size() - base == 2) begin
            check("gap_write0", {mon_addr[base], mon_data[base]}, {8'd0, 32'h00500013});
            check("gap_write1", {mon_addr[base+1], mon_data[base+1]}, {8'd1, 32'h000000B3});
        end
        check("single_cycle_strobe", 64'(dbl_we), 64'd0);

        // Empty image.
        pulse_reset();
        base = mon_addr.size();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("n0_start", {start, rdy, busy}, {1'b1, 1'b0, 1'b0});
        tick();
        check("n0_no_write", {64'(mon_addr.size() - base)}, 64'd0);

        // Overflow against the DEPTH=4 instance.
        pulse_reset();
        base = we4_cnt;
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        check("ovf_err_after_header", {err4, err}, {1'b1, 1'b0});
        for (int i = 0; i < 20; i++) send_byte(8'(i), 0);
        repeat (2) tick();
        check("ovf_write_count", 64'(we4_cnt - base), 64'd4);
        check("ovf_last", {last_addr4, wdata4, words4}, {8'd3, 32'h0F0E0D0C, 16'd4});
        check("ovf_no_start", {start4, rdy4, err4}, {1'b0, 1'b0, 1'b1});
        check("deep_instance_ok", {start, words, err}, {1'b1, 16'd5, 1'b0});
`else
        // Correct checksum (XOR of 02 00 13 00 50 00 B3 00 00 00 is F2).
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
        check("csum_wait", {busy, start}, {1'b1, 1'b0});
        send_byte(8'hF2, 0);
        check("csum_ok", {start, err, rdy, words}, {1'b1, 1'b0, 1'b0, 16'd2});

        // Corrupted checksum.
        pulse_reset();
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
        send_byte(8'hF3, 0);
        repeat (2) tick();
        check("csum_bad", {start, err, words}, {1'b0, 1'b1, 16'd2});

        // Reset mid-load, then reload from scratch.
        pulse_reset();
        for (int i = 0; i < 7; i++) send_byte(img[i], 0);
        pulse_reset();
        check("midload_reset", {words, busy, start}, {16'd0, 1'b0, 1'b0});
        base = mon_addr.size();
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
        send_byte(8'hF2, 0);
        check("reload_start", {start, err}, {1'b1, 1'b0});
        check("reload_count", 64'(mon_addr.size() - base), 64'd2);
        if (mon_addr.size() - base == 2) begin
            check("reload_write0", {mon_addr[base], mon_data[base]}, {8'd0, 32'h00500013});
            check("reload_write1", {mon_addr[base+1], mon_data[base+1]}, {8'd1, 32'h000000B3});
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
